// File: rtl/fetch_queue_pkg.sv
// Shared core constants for fetch, decode and noper logic: NOP encoding,
// register-field positions and the sequential PC increment.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam int          RS1_LSB  = 15;
  localparam int          RS2_LSB  = 20;
  localparam int          REG_W    = 5;
  localparam int          ENTRY_W  = 64;

  // Redirects always land on a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH x 64 bits, one synchronous write
// port, one asynchronous read port, contents never reset.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially into a FWFT buffer, flushed by
// decode/execute redirects. Define FETCH_QUEUE_PERF_EN to add perf counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = $clog2(DEPTH),
  parameter int          CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [31:0]   iaddr,
  input  logic [31:0]   idata,
  input  logic          iready_n,
  input  logic          keep,
  input  logic          branch_PC_early_contral,
  input  logic [31:0]   branch_PC_early,
  input  logic          branch_PC_contral,
  input  logic [31:0]   branch_PC,
  output logic          inst_valid,
  output logic [31:0]   Instraction_pype,
  output logic [31:0]   PC_pype0,
  output logic [31:0]   PCp4_pype0,
  output logic [4:0]    fornop_register1_pype,
  output logic [4:0]    fornop_register2_pype,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]   perf_fetch,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_flush,
`endif
  output logic [CW-1:0] q_count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               redirect, push, pop;
  logic [31:0]        redirect_pc;
  logic [ENTRY_W-1:0] head_entry;
  logic [31:0]        head_inst, head_pc;

  assign redirect    = branch_PC_contral | branch_PC_early_contral;
  assign redirect_pc = align_pc(branch_PC_contral ? branch_PC : branch_PC_early);

  // A pop never makes room for a push in the same cycle: fullness is judged
  // on the occupancy at the start of the cycle.
  assign push = !iready_n && (count_q < DEPTH_C) && !redirect;
  assign pop  = inst_valid && !keep && !redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + PC_INC;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({idata, fetch_pc_q}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  assign head_inst = head_entry[ENTRY_W-1:32];
  assign head_pc   = head_entry[31:0];

  assign iaddr      = fetch_pc_q;
  assign q_count    = count_q;
  assign inst_valid = (count_q != '0);

  // Empty queue presents a NOP at PC 0 so downstream never sees stale data.
  always_comb begin
    Instraction_pype      = NOP_INST;
    PC_pype0              = '0;
    fornop_register1_pype = '0;
    fornop_register2_pype = '0;
    if (inst_valid) begin
      Instraction_pype      = head_inst;
      PC_pype0              = head_pc;
      fornop_register1_pype = head_inst[RS1_LSB +: REG_W];
      fornop_register2_pype = head_inst[RS2_LSB +: REG_W];
    end
  end

  assign PCp4_pype0 = PC_pype0 + PC_INC;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push)              perf_fetch_q <= perf_fetch_q + 32'd1;
      if (inst_valid && keep) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect)          perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL use one clock, clk; reset is rst, synchronous and active-low.
REQ-004 SHALL have the following ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset.
- iaddr  output  32  instruction fetch address.
- idata  input  32  instruction word, valid when iready_n=0.
- iready_n  input  1  low means idata is valid this cycle.
- keep  input  1  decode stall; holds the head entry.
- branch_PC_early_contral  input  1  decode-stage redirect request.
- branch_PC_early  input  32  decode-stage redirect target.
- branch_PC_contral  input  1  execute-stage redirect request.
- branch_PC  input  32  execute-stage redirect target.
- inst_valid  output  1  the head entry is presented.
- Instraction_pype  output  32  head instruction.
- PC_pype0  output  32  head PC.
- PCp4_pype0  output  32  head PC+4.
- fornop_register1_pype  output  5  head rs1, bits [19:15].
- fornop_register2_pype  output  5  head rs2, bits [24:20].
- q_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-005 SHALL drive iaddr combinationally from the internal fetch_pc register.
REQ-006 SHALL push the pair {idata, fetch_pc} at the write pointer only when:
- iready_n=0,
- q_count<DEPTH, and
- no redirect is active.
On a push, fetch_pc advances by 4.
REQ-007 SHALL NOT push when the queue is full, even if a pop occurs in the same cycle; fetch_pc holds.
REQ-008 SHALL present the head entry as first-word-fall-through; inst_valid = (q_count!=0).
REQ-009 SHALL pop on a cycle where inst_valid=1 and keep=0.
REQ-010 SHALL leave q_count unchanged when a push and a pop occur in the same cycle.
REQ-011 SHALL, when the queue is empty, drive Instraction_pype=32'h0000_0013 (NOP), PC_pype0=0, PCp4_pype0=4, and both fornop register outputs to 0.
REQ-012 SHALL compute PCp4_pype0 as PC_pype0+4, modulo 2^32.
REQ-013 SHALL wrap the read and write pointers modulo DEPTH.
REQ-014 SHALL treat a redirect as branch_PC_contral OR branch_PC_early_contral.
REQ-015 SHALL give branch_PC_contral priority over branch_PC_early_contral when both are asserted.
REQ-016 SHALL, on a redirect, at the next edge: clear q_count and both pointers, load fetch_pc with the selected target with bits [1:0] forced to 0, and discard idata and any pop of that cycle.
REQ-017 SHALL give inst_valid=0 in the cycle after a redirect; the first new entry is presented no earlier than two cycles after the redirect.
REQ-018 SHALL hold all state while iready_n=1, apart from pops.
REQ-019 SHALL wrap fetch_pc from 32'hFFFF_FFFC to 0.

Reset
REQ-020 SHALL, at a clock edge with rst=0, set:
- q_count=0 and both pointers=0,
- fetch_pc=RESET_PC, so that iaddr=RESET_PC,
- inst_valid=0, and
- the empty-queue values of REQ-011 on all head outputs.
REQ-021 SHALL give rst priority over redirect, push and pop; a reset mid-operation discards all entries.
REQ-022 SHALL NOT reset the storage array contents.

Configuration
REQ-023 SHALL, when FETCH_QUEUE_PERF_EN is defined, add three 32-bit outputs, each reset to 0 and wrapping at 2^32:
- perf_fetch: count of pushes.
- perf_stall: count of cycles with inst_valid=1 and keep=1.
- perf_flush: count of redirects.
REQ-024 SHALL, when FETCH_QUEUE_PERF_EN is undefined, omit these ports and counters entirely, with otherwise identical behaviour.

Structure
REQ-025 SHALL take the NOP_INST constant (32'h0000_0013), the rs1/rs2 field positions and the PC increment (4) from the shared core package used by the decode and noper logic.
REQ-026 SHALL place the storage in one sub-module, fetch_queue_ram: DEPTH x 64 bits, one write port, one asynchronous read port, no reset.

Verification
REQ-027 Reset with RESET_PC=32'h100, then hold iready_n=0 and keep=1 for 6 cycles -> iaddr reads 0x100, 0x104, 0x108, 0x10C, then holds at 0x110; q_count=4; head PC=0x100.
REQ-028 With a full queue, release keep for 1 cycle while iready_n=0 -> exactly one pop; push resumes on the following cycle; the head becomes PC 0x104.
REQ-029 Assert branch_PC_early_contral (0x200) and branch_PC_contral (0x300) in the same cycle -> next iaddr=0x300; q_count=0; inst_valid=0.
REQ-030 Redirect to 0x203 -> iaddr=0x200.
REQ-031 Drive rst=0 mid-stream with q_count=3 -> the next cycle has q_count=0, iaddr=RESET_PC and Instraction_pype=0x00000013.
REQ-032 With FETCH_QUEUE_PERF_EN defined: 5 pushes, 3 stall cycles, 1 redirect -> perf_fetch=5, perf_stall=3, perf_flush=1.
